// File: rtl/lockin_collector_pkg.sv
// Shared types and default widths for the lock-in result collector.
package lockin_collector_pkg;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefCntW  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDone
  } state_e;

  // {i,q} pair at the default sample width.
  typedef struct packed {
    logic signed [DefDataW-1:0] i;
    logic signed [DefDataW-1:0] q;
  } pair_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible whenever not empty.
module sync_fifo_fwft #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             pop,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AddrW:0]   count
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_wr, do_pop;

  assign full   = (count_q == (AddrW+1)'(Depth));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign do_wr  = wr_en && !full;
  assign do_pop = pop && !empty;
  // Drive zeros while empty so the outputs read 0 out of reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      unique case ({do_wr, do_pop})
        2'b10:   count_q <= count_q + (AddrW+1)'(1);
        2'b01:   count_q <= count_q - (AddrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lockin_result_collector.sv
// Pairs I/Q samples, decimates, buffers kept pairs in a FWFT FIFO and stops after N results.
module lockin_result_collector
  import lockin_collector_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = DefCntW,
  localparam int unsigned CountW    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  decim_factor,
  input  logic [CNT_W-1:0]  n_results,
  input  logic [DATA_W-1:0] i_in,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] q_in,
  input  logic              q_in_valid,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CountW-1:0] fifo_count,
  output logic [CNT_W-1:0]  overflow_count,
  output logic              pair_error,
  output logic              capture_done
);

  logic [CNT_W-1:0] decim_q, n_results_q;
  logic [CNT_W-1:0] decim_cnt_q, captured_q, overflow_q;
  state_e           state_q;
  logic             pair_error_q, capture_done_q;

  logic [CNT_W-1:0]    decim_eff;
  logic                pair_event, keep, write, drop, last_write;
  logic                fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rd_data;

  assign decim_eff  = (decim_q == '0) ? CNT_W'(1) : decim_q;
  assign pair_event = (state_q == StCapture) && enable && i_in_valid && q_in_valid;
  assign keep       = pair_event && (decim_cnt_q == '0);
  // Full is judged before any same-cycle pop, so a pop never rescues a write.
  assign write      = keep && !fifo_full;
  assign drop       = keep && fifo_full;
  assign last_write = write && (n_results_q != '0) && ((captured_q + CNT_W'(1)) == n_results_q);

  // Configuration is only sampled while held in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      decim_q     <= decim_factor;
      n_results_q <= n_results;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      decim_cnt_q    <= '0;
      captured_q     <= '0;
      overflow_q     <= '0;
      pair_error_q   <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      if (i_in_valid ^ q_in_valid) begin
        pair_error_q <= 1'b1;
      end
      if (pair_event) begin
        decim_cnt_q <= (decim_cnt_q == decim_eff - CNT_W'(1)) ? '0 : decim_cnt_q + CNT_W'(1);
      end
      if (write) begin
        captured_q <= captured_q + CNT_W'(1);
      end
      if (drop && (overflow_q != '1)) begin
        overflow_q <= overflow_q + CNT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (last_write) begin
            state_q        <= StDone;
            capture_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .Width (2 * DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (write),
    .wr_data ({i_in, q_in}),
    .pop     (out_valid && out_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid      = !fifo_empty;
  assign out_i          = fifo_rd_data[2*DATA_W-1:DATA_W];
  assign out_q          = fifo_rd_data[DATA_W-1:0];
  assign overflow_count = overflow_q;
  assign pair_error     = pair_error_q;
  assign capture_done   = capture_done_q;

endmodule

// File: tb/tb_lockin_result_collector.sv
// Bench for lockin_result_collector: directed scenarios plus randomized traffic vs a queue model.
module tb_lockin_result_collector;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] decim_factor, n_results;
  logic [63:0] i_in, q_in, out_i, out_q;
  logic        i_in_valid, q_in_valid, out_valid, out_ready;
  logic [4:0]  fifo_count;
  logic [31:0] overflow_count;
  logic        pair_error, capture_done;

  always #5 clk = ~clk;

  lockin_result_collector dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .decim_factor   (decim_factor),
    .n_results      (n_results),
    .i_in           (i_in),
    .i_in_valid     (i_in_valid),
    .q_in           (q_in),
    .q_in_valid     (q_in_valid),
    .out_i          (out_i),
    .out_q          (out_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count),
    .overflow_count (overflow_count),
    .pair_error     (pair_error),
    .capture_done   (capture_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of buffered pairs plus spec-level counters.
  logic [127:0] m_q[$];
  int           m_state;  // 0 idle, 1 capture, 2 done
  int unsigned  m_d, m_n, m_dcnt, m_cap;
  logic [31:0]  m_ovf;
  bit           m_perr;

  logic [167:0] dut_status;
  assign dut_status = {out_valid, fifo_count, overflow_count, pair_error, capture_done,
                       out_i, out_q};

  function automatic logic [167:0] model_status();
    logic [127:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 128'd0;
    return {(m_q.size() != 0), 5'(m_q.size()), m_ovf, m_perr, (m_state == 2), head};
  endfunction

  task automatic do_reset(input logic [31:0] d, input logic [31:0] n);
    reset = 1'b1; decim_factor = d; n_results = n; enable = 1'b0;
    i_in_valid = 1'b0; q_in_valid = 1'b0; i_in = '0; q_in = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    // Config changes outside reset must have no effect.
    decim_factor = $urandom; n_results = $urandom;
    m_q.delete(); m_state = 0; m_d = (d == 0) ? 1 : d; m_n = n;
    m_dcnt = 0; m_cap = 0; m_ovf = '0; m_perr = 1'b0;
  endtask

  task automatic step(input bit en, input bit iv, input bit qv, input logic [63:0] i,
                      input logic [63:0] q, input bit rdy);
    bit pop, full, keep;
    enable = en; i_in_valid = iv; q_in_valid = qv; i_in = i; q_in = q; out_ready = rdy;
    pop  = (m_q.size() > 0) && rdy;
    full = (m_q.size() == 16);
    if (iv != qv) m_perr = 1'b1;
    if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1 && en && iv && qv) begin
      keep   = (m_dcnt == 0);
      m_dcnt = (m_dcnt + 1) % m_d;
      if (keep) begin
        if (full) begin
          if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
        end else begin
          m_q.push_back({i, q});
          m_cap++;
          if (m_n != 0 && m_cap == m_n) m_state = 2;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(1, 0);
    n_chk++;
    if (dut_status !== model_status() || dut_status !== 168'd0)
      $display("FAIL reset_state: got %h want %h", dut_status, model_status());
    else n_pass++;
  endtask

  task automatic test_n_results();
    int pops = 0;
    do_reset(1, 4);
    step(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      if (out_valid) pops++;
      if (k <= 5) step(1, 1, 1, 64'(k), 64'(-k), 1);
      else step(1, 0, 0, 0, 0, 1);
      n_chk++;
      if (dut_status !== model_status())
        $display("FAIL n_results k=%0d: got %h want %h", k, dut_status, model_status());
      else n_pass++;
    end
    n_chk++;
    if (pops != 4 || capture_done !== 1'b1)
      $display("FAIL n_results_total: got pops=%0d done=%b want pops=4 done=1", pops,
               capture_done);
    else n_pass++;
  endtask

  task automatic test_decim3();
    logic [63:0] outs[$];
    int maxc = 0;
    do_reset(3, 0);
    step(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      if (out_valid) outs.push_back(out_i);
      if (k < 9) step(1, 1, 1, 64'(k), ~64'(k), 1);
      else step(1, 0, 0, 0, 0, 1);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      n_chk++;
      if (dut_status !== model_status())
        $display("FAIL decim3 k=%0d: got %h want %h", k, dut_status, model_status());
      else n_pass++;
    end
    n_chk++;
    if (outs.size() != 3 || outs[0] !== 64'd0 || outs[1] !== 64'd3 || outs[2] !== 64'd6
        || maxc != 1)
      $display("FAIL decim3_outputs: got n=%0d maxc=%0d want n=3 I=0,3,6 maxc=1",
               outs.size(), maxc);
    else n_pass++;
  endtask

  task automatic test_overflow_drain();
    do_reset(1, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 1, 64'(k), 64'(k + 100), 0);
      n_chk++;
      if (dut_status !== model_status())
        $display("FAIL overflow_fill k=%0d: got %h want %h", k, dut_status, model_status());
      else n_pass++;
    end
    n_chk++;
    if (fifo_count !== 5'd16 || overflow_count !== 32'd4)
      $display("FAIL overflow_counts: got count=%0d ovf=%0d want 16 4", fifo_count,
               overflow_count);
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_i !== 64'(k) || out_q !== 64'(k + 100))
        $display("FAIL drain k=%0d: got v=%b i=%0d q=%0d want v=1 i=%0d q=%0d", k, out_valid,
                 out_i, out_q, k, k + 100);
      else n_pass++;
      step(0, 0, 0, 0, 0, 1);
    end
    n_chk++;
    if (dut_status !== model_status() || out_valid !== 1'b0)
      $display("FAIL drain_empty: got %h want %h", dut_status, model_status());
    else n_pass++;
  endtask

  task automatic test_full_write_pop();
    do_reset(1, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(1, 1, 1, 64'(k), 64'(k), 0);
    step(1, 1, 1, 64'd99, 64'd99, 1);
    n_chk++;
    if (dut_status !== model_status() || fifo_count !== 5'd15 || overflow_count !== 32'd1
        || out_i !== 64'd1)
      $display("FAIL full_write_pop: got %h want %h", dut_status, model_status());
    else n_pass++;
  endtask

  task automatic test_pair_error();
    do_reset(1, 0);
    step(0, 0, 1, 0, 3, 0);
    n_chk++;
    if (dut_status !== model_status() || pair_error !== 1'b1)
      $display("FAIL pair_error_idle: got %h want %h", dut_status, model_status());
    else n_pass++;
    do_reset(1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 64'd5, 64'd5, 0);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (dut_status !== model_status() || pair_error !== 1'b1 || fifo_count !== 5'd0)
        $display("FAIL pair_error_sticky k=%0d: got %h want %h", k, dut_status,
                 model_status());
      else n_pass++;
      step(1, 0, 0, 0, 0, 0);
    end
    step(1, 1, 1, 64'd7, 64'd7, 0);
    n_chk++;
    if (dut_status !== model_status())
      $display("FAIL pair_error_then_pair: got %h want %h", dut_status, model_status());
    else n_pass++;
    do_reset(1, 0);
    n_chk++;
    if (pair_error !== 1'b0)
      $display("FAIL pair_error_reset: got %b want 0", pair_error);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(1, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 1, 1, 64'(k), 64'(k), 0);
    n_chk++;
    if (fifo_count !== 5'd5)
      $display("FAIL reset_mid_fill: got %0d want 5", fifo_count);
    else n_pass++;
    do_reset(2, 0);
    n_chk++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0 || overflow_count !== 32'd0)
      $display("FAIL reset_mid_clear: got %h want %h", dut_status, model_status());
    else n_pass++;
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 1, 64'(k), 64'(k), 0);
    n_chk++;
    if (dut_status !== model_status() || fifo_count !== 5'd2 || out_i !== 64'd0)
      $display("FAIL reset_mid_new_decim: got %h want %h", dut_status, model_status());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int unsigned rdy_pct;
      do_reset($urandom_range(0, 4), $urandom_range(0, 12));
      rdy_pct = $urandom_range(10, 100);
      for (int c = 0; c < 150; c++) begin
        int unsigned sel;
        bit en, iv, qv, rdy;
        sel = $urandom_range(0, 19);
        en  = ($urandom_range(0, 7) != 0);
        iv  = (sel < 12) || (sel == 12);
        qv  = (sel < 12) || (sel == 13);
        rdy = ($urandom_range(1, 100) <= rdy_pct);
        step(en, iv, qv, {$urandom, $urandom}, {$urandom, $urandom}, rdy);
        n_chk++;
        if (dut_status !== model_status())
          $display("FAIL random r=%0d c=%0d: got %h want %h", r, c, dut_status,
                   model_status());
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_n_results();
    test_decim3();
    test_overflow_drain();
    test_full_write_pop();
    test_pair_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
